// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: matrix rows in, columns out, decoded key out.
interface keypad_scanner_if;
  logic [3:0] row;        // active-low rows, pulled up externally
  logic [3:0] col;        // active-low column drive, one-hot zero
  logic [3:0] key;        // accepted key code = 4*row + col
  logic       key_valid;  // high while accepted key is held
  logic       key_tick;   // one-cycle pulse on accepted press

  // scanner side
  modport master (input row, output col, key, key_valid, key_tick);
  // keypad / consumer side
  modport slave  (output row, input col, key, key_valid, key_tick);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, 2-flop row sync, full-scan
// snapshot, debounce FSM over DB_SCANS scans, registered key/valid/tick.
module keypad_scanner #(
  parameter int SCAN_DIV = 100000,  // clk cycles per column, >= 4
  parameter int DB_SCANS = 10       // matching scans to accept, >= 1
) (
  input  logic             clk,
  input  logic             reset,   // async, active low
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DB_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DB_SCANS);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    cidx_q;
  logic [3:0]    col_q;
  logic [15:0]   snap_q, snap_d;
  logic          done_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          tick_q, tick_d;
  logic [4:0]    nset;
  logic [3:0]    idx;
  logic          is_none, is_single;

  // Merge the current column's pressed rows (inverted sync rows) into the snapshot.
  always_comb begin
    snap_d = snap_q;
    for (int r = 0; r < 4; r++) snap_d[{r[1:0], cidx_q}] = ~row_s2_q[r];
  end

  // Row synchroniser, column divider/rotation, snapshot capture, scan-done strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      div_q    <= '0;
      cidx_q   <= 2'd0;
      col_q    <= 4'b1110;
      snap_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      row_s1_q <= kp.row;
      row_s2_q <= row_s1_q;
      done_q   <= 1'b0;
      if (div_q == DIV_LAST) begin
        // sample at slot end: rows have settled and crossed the synchroniser
        div_q  <= '0;
        snap_q <= snap_d;
        cidx_q <= cidx_q + 2'd1;
        col_q  <= ~(4'b0001 << (cidx_q + 2'd1));
        done_q <= (cidx_q == 2'd3);
      end else begin
        div_q <= div_q + DIV_ONE;
      end
    end
  end

  // Classify the completed snapshot: bit count and index of the last set bit.
  always_comb begin
    nset = '0;
    idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        nset = nset + 5'd1;
        idx  = 4'(i);
      end
    end
    is_none   = (nset == 5'd0);
    is_single = (nset == 5'd1);
  end

  // Debounce FSM next state; only acts on the scan-done strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    valid_d = valid_q;
    tick_d  = 1'b0;
    if (done_q) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = idx;
            if (DB_SCANS == 1) begin
              key_d = idx; valid_d = 1'b1; tick_d = 1'b1;
              cnt_d = CNT_MAX; state_d = HELD;
            end else begin
              cnt_d = CNT_ONE; state_d = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (is_single && idx == cand_q) begin
            if (cnt_q == CNT_MAX - CNT_ONE) begin
              key_d = cand_q; valid_d = 1'b1; tick_d = 1'b1;
              cnt_d = CNT_MAX; state_d = HELD;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (is_single) begin
            cand_d = idx; cnt_d = CNT_ONE;
          end else begin
            cnt_d = '0; state_d = IDLE;
          end
        end
        HELD: begin
          // multi-key and other single keys are ignored until a full release
          if (is_none) begin
            if (DB_SCANS == 1) begin
              valid_d = 1'b0; cnt_d = '0; state_d = IDLE;
            end else begin
              cnt_d = CNT_ONE; state_d = DEB_REL;
            end
          end
        end
        DEB_REL: begin
          if (is_none) begin
            if (cnt_q == CNT_MAX - CNT_ONE) begin
              valid_d = 1'b0; cnt_d = '0; state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = '0; state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Debounce FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key       = key_q;
  assign kp.key_valid = valid_q;
  assign kp.key_tick  = tick_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DB_SCANS=3 (16-cycle scan).
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0] row_m;
  int n_assert = 0;
  int n_fail = 0;
  int tick_total = 0;
  int last_ticks = 0;
  logic prev_tick = 1'b0;
  logic prev_valid = 1'b0;

  keypad_scanner_if kp_if();

  keypad_scanner #(.SCAN_DIV(4), .DB_SCANS(3)) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp_if)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !kp_if.col[c]) row_m[r] = 1'b0;
  end
  assign kp_if.row = row_m;

  // Tick monitor: every tick must be one cycle wide and follow key_valid low.
  always @(negedge clk) begin
    if (kp_if.key_tick) begin
      tick_total++;
      n_assert++;
      if (prev_tick || prev_valid) begin
        n_fail++;
        $display("FAIL tick_qual: prev_tick=%0b prev_valid=%0b required 0/0", prev_tick, prev_valid);
      end
    end
    prev_tick  = kp_if.key_tick;
    prev_valid = kp_if.key_valid;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    int          n;
    logic [3:0]  key;
    logic        valid;
    int          ticks;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl[NV];

  task automatic check_vec(input int j);
    chk($sformatf("v%0d_key", j), {4'h0, kp_if.key}, {4'h0, tbl[j].key});
    chk($sformatf("v%0d_valid", j), {7'h0, kp_if.key_valid}, {7'h0, tbl[j].valid});
    chk($sformatf("v%0d_ticks", j), 8'(tick_total - last_ticks), 8'(tbl[j].ticks));
    last_ticks = tick_total;
  endtask

  initial begin
    // {keys, scans, key, valid, ticks seen}
    tbl[0]  = '{16'h0040, 3, 4'd6,  1'b1, 1};  // press 6
    tbl[1]  = '{16'h0040, 2, 4'd6,  1'b1, 0};  // keep holding
    tbl[2]  = '{16'h0000, 2, 4'd6,  1'b1, 0};  // release debouncing
    tbl[3]  = '{16'h0000, 1, 4'd6,  1'b0, 0};  // release accepted, key kept
    tbl[4]  = '{16'h0200, 2, 4'd6,  1'b0, 0};  // bounce 9: two scans
    tbl[5]  = '{16'h0000, 1, 4'd6,  1'b0, 0};  // gap -> IDLE
    tbl[6]  = '{16'h0200, 2, 4'd6,  1'b0, 0};
    tbl[7]  = '{16'h0200, 1, 4'd9,  1'b1, 1};  // third stable scan
    tbl[8]  = '{16'h0000, 3, 4'd9,  1'b0, 0};
    tbl[9]  = '{16'h0021, 4, 4'd9,  1'b0, 0};  // ghost 0+5
    tbl[10] = '{16'h0000, 1, 4'd9,  1'b0, 0};
    tbl[11] = '{16'h0008, 3, 4'd3,  1'b1, 1};  // press 3
    tbl[12] = '{16'h1008, 3, 4'd3,  1'b1, 0};  // add 12 (multi)
    tbl[13] = '{16'h1000, 4, 4'd3,  1'b1, 0};  // only 12: still held
    tbl[14] = '{16'h0000, 1, 4'd3,  1'b1, 0};  // start release
    tbl[15] = '{16'h1000, 1, 4'd3,  1'b1, 0};  // back to HELD
    tbl[16] = '{16'h0000, 3, 4'd3,  1'b0, 0};
    tbl[17] = '{16'h1000, 3, 4'd12, 1'b1, 1};  // 12 pressed again
    tbl[18] = '{16'h0000, 3, 4'd12, 1'b0, 0};
    tbl[19] = '{16'h0020, 2, 4'd12, 1'b0, 0};  // candidate 5
    tbl[20] = '{16'h0400, 2, 4'd12, 1'b0, 0};  // switch to 10, restart count
    tbl[21] = '{16'h0400, 1, 4'd10, 1'b1, 1};
    tbl[22] = '{16'h0000, 3, 4'd10, 1'b0, 0};
    tbl[23] = '{16'h0040, 3, 4'd6,  1'b1, 1};  // hold 6 for reset test

    // reset state
    repeat (5) @(negedge clk);
    chk("rst_col", {4'h0, kp_if.col}, 8'h0E);
    chk("rst_key", {4'h0, kp_if.key}, 8'h00);
    chk("rst_valid", {7'h0, kp_if.key_valid}, 8'h00);
    chk("rst_tick", {7'h0, kp_if.key_tick}, 8'h00);
    reset = 1'b1;

    // two full column rotations, 4 cycles per column
    for (int k = 0; k < 32; k++) begin
      logic [3:0] one;
      one = 4'b0001;
      chk($sformatf("col_seq%0d", k), {4'h0, kp_if.col}, {4'h0, ~(one << ((k / 4) % 4))});
      @(negedge clk);
    end

    // table: keys applied at scan start, results checked 2 cycles into next scan
    for (int i = 0; i < NV; i++) begin
      keys = tbl[i].keys;
      for (int s = 0; s < tbl[i].n; s++) begin
        repeat (2) @(negedge clk);
        if (s == 0 && i > 0) check_vec(i - 1);
        repeat (14) @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);
    check_vec(NV - 1);

    // asynchronous reset mid-hold, between clock edges
    #2 reset = 1'b0;
    #1;
    chk("arst_col", {4'h0, kp_if.col}, 8'h0E);
    chk("arst_key", {4'h0, kp_if.key}, 8'h00);
    chk("arst_valid", {7'h0, kp_if.key_valid}, 8'h00);
    chk("arst_tick", {7'h0, kp_if.key_tick}, 8'h00);
    #9 reset = 1'b1;
    last_ticks = tick_total;
    repeat (48) @(negedge clk);
    chk("arst_notick_early", 8'(tick_total - last_ticks), 8'd0);
    chk("arst_valid_early", {7'h0, kp_if.key_valid}, 8'h00);
    @(negedge clk);
    chk("arst_tick_after3", {7'h0, kp_if.key_tick}, 8'h01);
    chk("arst_key_after3", {4'h0, kp_if.key}, 8'h06);
    chk("arst_valid_after3", {7'h0, kp_if.key_valid}, 8'h01);
    repeat (20) @(negedge clk);
    chk("arst_single_tick", 8'(tick_total - last_ticks), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
